// File: rtl/bram_addresser_with_bram_banks.sv
// bram_addresser_with_bram_banks: 16 KiB data memory of four byte lanes.
// Byte-enabled stores, masked loads returned on a registered writeback output.
`default_nettype none

module bram_lane #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout;

  // Array contents are deliberately left out of reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout <= '0;
    end else if (re_i) begin
      dout <= mem[addr_i];
    end
  end

  assign dout_o = dout;

endmodule

module bram_addresser_with_bram_banks #(
  parameter int WORD_ADDR_WIDTH = 12,
  parameter int LANE_WIDTH      = 8
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [31:0]             memory_address,
  input  logic [4*LANE_WIDTH-1:0] data_to_store,
  input  logic [4:0]              memory_access_code,
  output logic [4*LANE_WIDTH-1:0] writeback_register_data
);

  localparam int c_NUM_LANES = 4;

  logic                       w_store;
  logic                       w_load;
  logic                       w_re;
  logic [WORD_ADDR_WIDTH-1:0] w_word_idx;
  logic [c_NUM_LANES-1:0]     w_we;
  logic [LANE_WIDTH-1:0]      w_lane_dout [c_NUM_LANES];

  logic                          load_q, load_d;
  logic [c_NUM_LANES-1:0]        mask_q, mask_d;
  logic [4*LANE_WIDTH-1:0]       wb_q, wb_d;

  // Byte offset and bits above 16 KiB take no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{memory_address[31:WORD_ADDR_WIDTH+2], memory_address[1:0]};

  assign w_word_idx = memory_address[WORD_ADDR_WIDTH+1:2];
  assign w_store    = memory_access_code[4];
  assign w_load     = ~memory_access_code[4] & (|memory_access_code[3:0]);
  assign w_re       = w_load & ~reset;
  assign w_we       = memory_access_code[3:0] & {c_NUM_LANES{w_store & ~reset}};

  bram_lane #(.ADDR_WIDTH(WORD_ADDR_WIDTH), .DATA_WIDTH(LANE_WIDTH)) bram0 (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .we_i   (w_we[0]),
    .re_i   (w_re),
    .addr_i (w_word_idx),
    .din_i  (data_to_store[0*LANE_WIDTH +: LANE_WIDTH]),
    .dout_o (w_lane_dout[0])
  );

  bram_lane #(.ADDR_WIDTH(WORD_ADDR_WIDTH), .DATA_WIDTH(LANE_WIDTH)) bram1 (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .we_i   (w_we[1]),
    .re_i   (w_re),
    .addr_i (w_word_idx),
    .din_i  (data_to_store[1*LANE_WIDTH +: LANE_WIDTH]),
    .dout_o (w_lane_dout[1])
  );

  bram_lane #(.ADDR_WIDTH(WORD_ADDR_WIDTH), .DATA_WIDTH(LANE_WIDTH)) bram2 (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .we_i   (w_we[2]),
    .re_i   (w_re),
    .addr_i (w_word_idx),
    .din_i  (data_to_store[2*LANE_WIDTH +: LANE_WIDTH]),
    .dout_o (w_lane_dout[2])
  );

  bram_lane #(.ADDR_WIDTH(WORD_ADDR_WIDTH), .DATA_WIDTH(LANE_WIDTH)) bram3 (
    .clk_i  (CLOCK_50),
    .rst_i  (reset),
    .we_i   (w_we[3]),
    .re_i   (w_re),
    .addr_i (w_word_idx),
    .din_i  (data_to_store[3*LANE_WIDTH +: LANE_WIDTH]),
    .dout_o (w_lane_dout[3])
  );

  // The enables travel alongside the lane read so the mask lines up with the data.
  always_comb begin
    load_d = w_load;
    mask_d = w_load ? memory_access_code[3:0] : mask_q;
    wb_d   = wb_q;
    if (load_q) begin
      for (int i = 0; i < c_NUM_LANES; i++) begin
        wb_d[i*LANE_WIDTH +: LANE_WIDTH] = mask_q[i] ? w_lane_dout[i] : '0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      load_q <= 1'b0;
      mask_q <= '0;
      wb_q   <= '0;
    end else begin
      load_q <= load_d;
      mask_q <= mask_d;
      wb_q   <= wb_d;
    end
  end

  assign writeback_register_data = wb_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_addresser_with_bram_banks.sv
// Scoreboarded bench for bram_addresser_with_bram_banks: directed plan plus random traffic.
`default_nettype none

module tb_bram_addresser_with_bram_banks;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [4:0]  code;
  logic [31:0] wb;

  always #5 clk = ~clk;

  bram_addresser_with_bram_banks dut (
    .CLOCK_50                (clk),
    .reset                   (rst),
    .memory_address          (addr),
    .data_to_store           (din),
    .memory_access_code      (code),
    .writeback_register_data (wb)
  );

  typedef struct {
    int          due;
    logic [31:0] val;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm [0:16383];
  int          cnt   = 0;
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_wb = 32'h0;
  bit          armed  = 1'b0;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [3:0] en);
    logic [31:0] r;
    int          base;
    r    = 32'h0;
    base = int'(a[13:0]) & ~3;
    for (int i = 0; i < 4; i++)
      if (en[i]) r[8*i +: 8] = mm[base + i];
    return r;
  endfunction

  task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic [4:0] c);
    int base;
    @(negedge clk);
    rst  = r;
    addr = a;
    din  = d;
    code = c;
    @(posedge clk);
    cnt++;
    #1;
    base = int'(a[13:0]) & ~3;
    if (r) begin
      q.delete();
      q.push_back('{cnt, 32'h0});
    end else if (c[4]) begin
      for (int i = 0; i < 4; i++)
        if (c[i]) mm[base + i] = d[8*i +: 8];
    end else if (c[3:0] != 4'h0) begin
      q.push_back('{cnt + 1, model_read(a, c[3:0])});
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].due == cnt) begin
      exp_wb = q[0].val;
      void'(q.pop_front());
      armed = 1'b1;
    end
    if (armed) begin
      total++;
      if (wb !== exp_wb) begin
        bad++;
        $display("FAIL wb cycle=%0d got=%h want=%h", cnt, wb, exp_wb);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [4:0]  c;
    int          sel;
    rst = 1'b1; addr = '0; din = '0; code = '0;
    cyc(1, 0, 0, 5'b00000);
    cyc(1, 0, 0, 5'b00000);

    // Full-word stores and lane placement.
    cyc(0, 0, 32'hF0F1F2F3, 5'b11111);
    cyc(0, 4, 32'hA0A1A2A3, 5'b11111);
    chk8("bram0.mem[0]", dut.bram0.mem[0], 8'hF3);
    chk8("bram1.mem[0]", dut.bram1.mem[0], 8'hF2);
    chk8("bram2.mem[0]", dut.bram2.mem[0], 8'hF1);
    chk8("bram3.mem[0]", dut.bram3.mem[0], 8'hF0);
    cyc(0, 0, 0, 5'b01111);
    cyc(0, 4, 0, 5'b01111);

    // Partial store, byte-enabled loads, alignment and aliasing.
    cyc(0, 0, 32'hEEEEEEEE, 5'b10101);
    cyc(0, 0, 0, 5'b01111);
    cyc(0, 4, 0, 5'b00011);
    cyc(0, 4, 0, 5'b01000);
    cyc(0, 6, 0, 5'b01111);
    cyc(0, 16384 + 8, 32'h12345678, 5'b11111);
    cyc(0, 8, 0, 5'b01111);
    chk8("bram3.mem[2]", dut.bram3.mem[2], 8'h12);

    // Hold across a store, an empty-enable store and idles.
    cyc(0, 0, 32'hF0F1F2F3, 5'b11111);
    cyc(0, 0, 0, 5'b01111);
    cyc(0, 12, 32'hDEADBEEF, 5'b11111);
    cyc(0, 12, 32'h00000000, 5'b10000);
    repeat (3) cyc(0, 0, 0, 5'b00000);

    // Reset during an in-flight load, with a store presented in the reset cycle.
    cyc(0, 0, 0, 5'b01111);
    cyc(1, 0, 32'h55555555, 5'b11111);
    cyc(0, 0, 0, 5'b00000);
    cyc(0, 0, 0, 5'b01111);
    cyc(0, 0, 0, 5'b00000);
    chk8("bram0.mem[0] after reset", dut.bram0.mem[0], 8'hF3);

    // Random traffic over 16 words, every word initialised first.
    for (int w = 0; w < 16; w++)
      cyc(0, 32'(w * 4), $urandom(), 5'b11111);
    for (int n = 0; n < 500; n++) begin
      a   = ($urandom() & 32'hFFFFC000) | 32'(($urandom_range(0, 15)) << 2) | ($urandom() & 32'h3);
      sel = $urandom_range(0, 39);
      c   = {1'b0, 4'($urandom())};
      if (sel == 0)       cyc(1, a, $urandom(), {1'b1, c[3:0]});
      else if (sel < 6)   cyc(0, a, $urandom(), 5'b00000);
      else if (sel < 20)  cyc(0, a, $urandom(), {1'b1, c[3:0]});
      else                cyc(0, a, $urandom(), c);
    end
    repeat (4) cyc(0, 0, 0, 5'b00000);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
